// File: rtl/pdes_pkg.sv
// Shared PDES definitions: scheduler state, heap operation class and heap sizing.
package pdes_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef enum logic {
    ENQ = 1'b0,
    DEQ = 1'b1
  } class_t;

  localparam int unsigned HEAP_DEPTH = 31;

  // Round-robin successor of idx among n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/event_heap_sched_if.sv
// Core-side request/grant bundle of the event heap scheduler.
interface event_heap_sched_if #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned NUM_CORES = 4
);

  logic [NUM_CORES-1:0]       enq_req;
  logic [NUM_CORES*WIDTH-1:0] enq_data;
  logic [NUM_CORES-1:0]       enq_gnt;
  logic [NUM_CORES-1:0]       deq_req;
  logic [NUM_CORES-1:0]       deq_gnt;
  logic [NUM_CORES-1:0]       deq_vld;
  logic [WIDTH-1:0]           deq_data;

  modport master (
    output enq_req, enq_data, deq_req,
    input  enq_gnt, deq_gnt, deq_vld, deq_data
  );

  modport slave (
    input  enq_req, enq_data, deq_req,
    output enq_gnt, deq_gnt, deq_vld, deq_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic        found;
  int unsigned cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr) + k) % N;
      if (en && !found && req[IW'(cand)]) begin
        gnt[IW'(cand)] = 1'b1;
        idx            = IW'(cand);
        found          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/event_heap_sched.sv
// Arbitrates core enqueue/dequeue requests onto a shared min-heap while
// enforcing its issue rules, and generates the heap's synchronous reset.
module event_heap_sched
  import pdes_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned NUM_CORES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  event_heap_sched_if.slave    core,
  output logic                 heap_enq,
  output logic                 heap_deq,
  output logic [WIDTH-1:0]     heap_inp,
  input  logic [WIDTH-1:0]     heap_out,
  input  logic                 heap_full,
  input  logic                 heap_empty,
  output logic                 heap_rst_n,
  output logic [31:0]          enq_total,
  output logic [31:0]          deq_total
);

  localparam int unsigned IDXW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  state_t                state_q, state_d;
  class_t                pref_q, pref_d;
  logic [IDXW-1:0]       enq_ptr_q, enq_ptr_d, deq_ptr_q, deq_ptr_d;
  logic [IDXW-1:0]       enq_idx, deq_idx;
  logic [NUM_CORES-1:0]  enq_gnt, deq_gnt, deq_vld_q;
  logic [WIDTH-1:0]      deq_data_q;
  logic [WIDTH-1:0]      slice [NUM_CORES];
  logic                  heap_rst_n_q;
  logic [31:0]           enq_total_q, deq_total_q;
  logic                  run, enq_elig, deq_elig, pick_enq, pick_deq;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_slice
    assign slice[i] = core.enq_data[i*WIDTH +: WIDTH];
  end

  // Class selection: a single grant per cycle, pref breaks ties.
  assign run      = (state_q == RUN);
  assign enq_elig = run && (|core.enq_req) && !heap_full;
  assign deq_elig = run && (|core.deq_req) && !heap_empty;
  assign pick_enq = enq_elig && (!deq_elig || pref_q == ENQ);
  assign pick_deq = deq_elig && !pick_enq;

  rr_arbiter #(.N(NUM_CORES)) u_enq_arb (
    .req (core.enq_req),
    .ptr (enq_ptr_q),
    .en  (pick_enq),
    .gnt (enq_gnt),
    .idx (enq_idx)
  );

  rr_arbiter #(.N(NUM_CORES)) u_deq_arb (
    .req (core.deq_req),
    .ptr (deq_ptr_q),
    .en  (pick_deq),
    .gnt (deq_gnt),
    .idx (deq_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= INIT;
      pref_q    <= ENQ;
      enq_ptr_q <= '0;
      deq_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      pref_q    <= pref_d;
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
    end
  end

  // Next state, pointer/preference updates and heap strobes.
  always_comb begin
    state_d   = state_q;
    pref_d    = pref_q;
    enq_ptr_d = enq_ptr_q;
    deq_ptr_d = deq_ptr_q;
    heap_enq  = 1'b0;
    heap_deq  = 1'b0;
    heap_inp  = '0;
    unique case (state_q)
      INIT:    state_d = RUN;
      RUN:     if (pick_enq) state_d = GAP;
      GAP:     state_d = RUN;
      default: state_d = INIT;
    endcase
    if (pick_enq) begin
      heap_enq  = 1'b1;
      heap_inp  = slice[enq_idx];
      enq_ptr_d = IDXW'(rr_next(32'(enq_idx), NUM_CORES));
    end
    if (pick_deq) begin
      heap_deq  = 1'b1;
      deq_ptr_d = IDXW'(rr_next(32'(deq_idx), NUM_CORES));
    end
    if (enq_elig && deq_elig) pref_d = (pref_q == ENQ) ? DEQ : ENQ;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      heap_rst_n_q <= 1'b0;
      deq_vld_q    <= '0;
      deq_data_q   <= '0;
      enq_total_q  <= '0;
      deq_total_q  <= '0;
    end else begin
      heap_rst_n_q <= 1'b1;
      deq_vld_q    <= deq_gnt;
      if (pick_deq) deq_data_q  <= heap_out;
      if (pick_enq) enq_total_q <= enq_total_q + 32'd1;
      if (pick_deq) deq_total_q <= deq_total_q + 32'd1;
    end
  end

  assign core.enq_gnt  = enq_gnt;
  assign core.deq_gnt  = deq_gnt;
  assign core.deq_vld  = deq_vld_q;
  assign core.deq_data = deq_data_q;
  assign heap_rst_n    = heap_rst_n_q;
  assign enq_total     = enq_total_q;
  assign deq_total     = deq_total_q;

endmodule
